// File: rtl/alu_nibble_sequencer_if.sv
// Handshake bundle for the nibble-serial add/subtract unit.
// Master drives operands and result acceptance; slave is the ALU block.
interface alu_nibble_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        carry_out;
  logic        overflow;
  logic        is_not_equal;
  logic        is_less_than;

  modport master (
    output in_valid, op_sub, data_a, data_b, out_ready,
    input  in_ready, out_valid, result, carry_out,
    input  overflow, is_not_equal, is_less_than
  );

  modport slave (
    input  in_valid, op_sub, data_a, data_b, out_ready,
    output in_ready, out_valid, result, carry_out,
    output overflow, is_not_equal, is_less_than
  );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// 32-bit add/sub computed one nibble per cycle through a single
// 4-bit carry-select slice; result presented on an output handshake.
module alu_nibble_sequencer (
  input logic                   clock,
  input logic                   reset,
  alu_nibble_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sub_q, sub_d;
  logic        carry_q, carry_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] result_q, result_d;
  logic        cout_q, cout_d;
  logic        ovf_q, ovf_d;
  logic        ne_q, ne_d;
  logic        lt_q, lt_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;

  logic [3:0]  a_nib;
  logic [3:0]  b_nib;
  logic [2:0]  lo;
  logic [2:0]  hi0;
  logic [2:0]  hi1;
  logic [2:0]  hi;
  logic [3:0]  sum;
  logic        cy;

  // Carry-select nibble slice: low pair ripples, high pair picks
  // between two precomputed candidates using the low-pair carry.
  always_comb begin
    a_nib = a_q[{k_q, 2'b00} +: 4];
    b_nib = b_q[{k_q, 2'b00} +: 4];
    lo    = {1'b0, a_nib[1:0]} + {1'b0, b_nib[1:0]}
          + {2'b00, carry_q};
    hi0   = {1'b0, a_nib[3:2]} + {1'b0, b_nib[3:2]};
    hi1   = {1'b0, a_nib[3:2]} + {1'b0, b_nib[3:2]} + 3'd1;
    hi    = lo[2] ? hi1 : hi0;
    sum   = {hi[1:0], lo[1:0]};
    cy    = hi[2];
  end

  // Next-state and datapath updates for IDLE -> RUN -> DONE.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    carry_d     = carry_q;
    k_d         = k_q;
    result_d    = result_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    ne_d        = ne_q;
    lt_d        = lt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.data_a;
          b_d        = bus.data_b ^ {32{bus.op_sub}};
          sub_d      = bus.op_sub;
          carry_d    = bus.op_sub;
          k_d        = 3'd0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        result_d[{k_q, 2'b00} +: 4] = sum;
        carry_d = cy;
        k_d     = k_q + 3'd1;
        if (k_q == 3'd7) begin
          cout_d      = cy;
          ovf_d       = (a_q[31] == b_q[31])
                      && (sum[3] != a_q[31]);
          ne_d        = sub_q && (|result_d);
          lt_d        = sub_q && (sum[3] ^ ovf_d);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // All state and outputs registered; reset wins over everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      carry_q     <= 1'b0;
      k_q         <= '0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ne_q        <= 1'b0;
      lt_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      carry_q     <= carry_d;
      k_q         <= k_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      ne_q        <= ne_d;
      lt_q        <= lt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.result       = result_q;
  assign bus.carry_out    = cout_q;
  assign bus.overflow     = ovf_q;
  assign bus.is_not_equal = ne_q;
  assign bus.is_less_than = lt_q;
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for the nibble-serial add/sub unit: vector table
// plus backpressure and mid-operation reset sequences.
module tb_alu_nibble_sequencer;
  logic clock;
  logic reset;

  alu_nibble_sequencer_if bus ();

  alu_nibble_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags_now();
    return {bus.carry_out, bus.overflow,
            bus.is_not_equal, bus.is_less_than};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int cyc;
    chk({tag, " in_ready pre"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.op_sub   = v.sub;
    bus.data_a   = v.a;
    bus.data_b   = v.b;
    tick();
    bus.in_valid = 1'b0;
    bus.data_a   = 32'hDEAD_BEEF;
    bus.data_b   = 32'h0BAD_F00D;
    chk({tag, " in_ready run"}, {31'd0, bus.in_ready}, 32'd0);
    wait_out(cyc);
    chk({tag, " latency"}, cyc, 32'd8);
    chk({tag, " result"}, bus.result, v.res);
    chk({tag, " flags"}, {28'd0, flags_now()}, {28'd0, v.flags});
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, " out_valid post"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, " in_ready post"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  vec_t vecs[10];
  vec_t bp_a;
  vec_t bp_b;
  vec_t rs;

  initial begin
    // flags = {carry_out, overflow, is_not_equal, is_less_than}
    vecs[0] = '{1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1000};
    vecs[1] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0100};
    vecs[2] = '{1'b0, 32'h0000_000F, 32'h0000_0001, 32'h0000_0010, 4'b0000};
    vecs[3] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b0011};
    vecs[4] = '{1'b1, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 4'b1000};
    vecs[5] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b1111};
    vecs[6] = '{1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 4'b0110};
    vecs[7] = '{1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 4'b0000};
    vecs[8] = '{1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 4'b1011};
    vecs[9] = '{1'b0, 32'h89AB_CDEF, 32'h7654_3210, 32'hFFFF_FFFF, 4'b0000};
    bp_a = '{1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 4'b0000};
    bp_b = '{1'b1, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 4'b1010};
    rs   = '{1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 4'b0000};

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op_sub    = 1'b0;
    bus.data_a    = '0;
    bus.data_b    = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    chk("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset result", bus.result, 32'd0);
    chk("reset flags", {28'd0, flags_now()}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: DONE held with new operands offered
    begin
      int cyc;
      bus.in_valid = 1'b1;
      bus.op_sub   = bp_a.sub;
      bus.data_a   = bp_a.a;
      bus.data_b   = bp_a.b;
      tick();
      bus.in_valid = 1'b0;
      wait_out(cyc);
      chk("bp latency", cyc, 32'd8);
      for (int i = 0; i < 5; i++) begin
        bus.in_valid = i[0] ? 1'b0 : 1'b1;
        bus.op_sub   = i[1];
        bus.data_a   = $urandom;
        bus.data_b   = $urandom;
        tick();
        chk("bp out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("bp in_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("bp result", bus.result, bp_a.res);
        chk("bp flags", {28'd0, flags_now()}, {28'd0, bp_a.flags});
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("bp release in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("bp release out_valid", {31'd0, bus.out_valid}, 32'd0);
      run_op(bp_b, "bp next");
    end

    // Reset during the 4th RUN cycle discards the operation
    begin
      int seen;
      bus.in_valid = 1'b1;
      bus.op_sub   = rs.sub;
      bus.data_a   = rs.a;
      bus.data_b   = rs.b;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst in_ready", {31'd0, bus.in_ready}, 32'd1);
      chk("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst result", bus.result, 32'd0);
      chk("rst flags", {28'd0, flags_now()}, 32'd0);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (bus.out_valid) seen++;
      end
      chk("rst no result", seen, 32'd0);
      run_op(rs, "rst next");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
